// File: rtl/rgb565_to_gray.sv
// RGB565 -> 8-bit luma, gated to PIC_W x PIC_H pixel frames, 3-stage pipeline.
// Define GRAY_ROUND_EN for round-to-nearest luma; default build truncates.
module rgb565_to_gray #(
   parameter int unsigned PIC_W     = 480,
   parameter int unsigned PIC_H     = 272,
   parameter int unsigned PIX_CNT_W = 24
) (
   input  logic        tft_clk,
   input  logic        tft_rst,
   input  logic        vs_in,
   input  logic        pi_flag,
   input  logic [15:0] pi_data,
   output logic        po_flag,
   output logic [7:0]  po_data,
   output logic        frame_done,
   output logic        frame_err
);

   localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(PIC_W * PIC_H - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                 state_q, state_d;
   logic [PIX_CNT_W-1:0]   cnt_q, cnt_d;
   logic [PIX_CNT_W-1:0]   base_w;
   logic                   err_q, err_d;
   logic                   accept_w, last_w;

   logic                   v1_q, l1_q;
   logic [7:0]             r8_q, g8_q, b8_q;
   logic                   v2_q, l2_q;
   logic [15:0]            pr_q, pg_q, pb_q;
   logic [15:0]            sum_w;
   logic [7:0]             y_w;
   logic                   po_flag_q, done_q;
   logic [7:0]             po_data_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      accept_w = 1'b0;
      last_w   = 1'b0;
      // A mid-frame vs_in restarts the count so a coincident pixel becomes pixel 0
      base_w   = vs_in ? '0 : cnt_q;
      case (state_q)
         IDLE: begin
            if (vs_in) begin
               state_d = ACTIVE;
               cnt_d   = '0;
            end
         end
         ACTIVE: begin
            err_d = vs_in && (cnt_q != '0);
            cnt_d = base_w;
            if (pi_flag) begin
               accept_w = 1'b1;
               if (base_w == LAST_PIX) begin
                  last_w  = 1'b1;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = base_w + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
`ifdef GRAY_ROUND_EN
      sum_w = pr_q + pg_q + pb_q + 16'd128;
`else
      sum_w = pr_q + pg_q + pb_q;
`endif
      y_w = 8'(sum_w >> 8);
   end

   always_ff @(posedge tft_clk) begin
      if (tft_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         v1_q      <= 1'b0;
         l1_q      <= 1'b0;
         r8_q      <= '0;
         g8_q      <= '0;
         b8_q      <= '0;
         v2_q      <= 1'b0;
         l2_q      <= 1'b0;
         pr_q      <= '0;
         pg_q      <= '0;
         pb_q      <= '0;
         po_flag_q <= 1'b0;
         done_q    <= 1'b0;
         po_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;

         v1_q <= accept_w;
         l1_q <= last_w;
         if (accept_w) begin
            r8_q <= {pi_data[15:11], pi_data[15:13]};
            g8_q <= {pi_data[10:5],  pi_data[10:9]};
            b8_q <= {pi_data[4:0],   pi_data[4:2]};
         end

         v2_q <= v1_q;
         l2_q <= l1_q;
         if (v1_q) begin
            pr_q <= 16'(r8_q) * 16'd77;
            pg_q <= 16'(g8_q) * 16'd150;
            pb_q <= 16'(b8_q) * 16'd29;
         end

         po_flag_q <= v2_q;
         done_q    <= v2_q && l2_q;
         if (v2_q) po_data_q <= y_w;
      end
   end

   assign po_flag    = po_flag_q;
   assign po_data    = po_data_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_rgb565_to_gray.sv
// Directed bench for rgb565_to_gray on a 4x3 frame; expected luma values are hand-computed.
module tb_rgb565_to_gray;

   logic        tft_clk = 1'b0;
   logic        tft_rst;
   logic        vs_in;
   logic        pi_flag;
   logic [15:0] pi_data;
   logic        po_flag;
   logic [7:0]  po_data;
   logic        frame_done;
   logic        frame_err;

   rgb565_to_gray #(
      .PIC_W     (4),
      .PIC_H     (3),
      .PIX_CNT_W (8)
   ) dut (
      .tft_clk    (tft_clk),
      .tft_rst    (tft_rst),
      .vs_in      (vs_in),
      .pi_flag    (pi_flag),
      .pi_data    (pi_data),
      .po_flag    (po_flag),
      .po_data    (po_data),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   always #5 tft_clk = ~tft_clk;

   int unsigned total = 0;
   int unsigned bad   = 0;
   string       sec   = "init";

   logic [15:0] pix_tab  [7];
   logic [7:0]  gray_tab [7];

   // Expected outputs delayed through the 3-stage pipeline
   logic        ev [3];
   logic        el [3];
   logic [7:0]  ed [3];
   logic [7:0]  hold_d;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s/%s got=%0h exp=%0h at %0t", sec, tag, got, exp, $time);
      end
   endtask

   task automatic tick(input logic rst, input logic vs, input logic pf, input int k,
                       input logic acc, input logic last, input logic err);
      logic [7:0] exp_data;
      tft_rst = rst;
      vs_in   = vs;
      pi_flag = pf;
      pi_data = (k >= 0) ? pix_tab[k] : 16'hA5A5;
      @(posedge tft_clk);
      #1;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            ev[i] = 1'b0;
            el[i] = 1'b0;
            ed[i] = 8'h00;
         end
         hold_d = 8'h00;
      end else begin
         ev[2] = ev[1]; el[2] = el[1]; ed[2] = ed[1];
         ev[1] = ev[0]; el[1] = el[0]; ed[1] = ed[0];
         ev[0] = acc;
         el[0] = acc && last;
         ed[0] = (acc && k >= 0) ? gray_tab[k] : 8'h00;
      end
      exp_data = ev[2] ? ed[2] : hold_d;
      hold_d   = exp_data;
      chk("po_flag",    32'(po_flag),    32'(ev[2]));
      chk("po_data",    32'(po_data),    32'(exp_data));
      chk("frame_done", 32'(frame_done), 32'(ev[2] && el[2]));
      chk("frame_err",  32'(frame_err),  32'(err));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      pix_tab = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'h0000, 16'h8410, 16'h1234};
`ifdef GRAY_ROUND_EN
      gray_tab = '{8'd255, 8'd77, 8'd149, 8'd29, 8'd0, 8'd131, 8'd64};
`else
      gray_tab = '{8'd255, 8'd76, 8'd149, 8'd28, 8'd0, 8'd130, 8'd63};
`endif
      for (int i = 0; i < 3; i++) begin
         ev[i] = 1'b0; el[i] = 1'b0; ed[i] = 8'h00;
      end
      hold_d  = 8'h00;
      tft_rst = 1'b1;
      vs_in   = 1'b0;
      pi_flag = 1'b0;
      pi_data = 16'h0000;

      sec = "reset";
      tick(1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

      sec = "no_vs";
      for (int i = 0; i < 100; i++) tick(1'b0, 1'b0, 1'b1, i % 7, 1'b0, 1'b0, 1'b0);

      sec = "colors";
      tick(1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, i, 1'b1, 1'b0, 1'b0);
      idle(4);
      tick(1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

      sec = "frame";
      tick(1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) begin
         if (i % 3 == 1) idle(1);
         tick(1'b0, 1'b0, 1'b1, i % 7, (i < 12), (i == 11), 1'b0);
      end
      idle(4);

      sec = "restart";
      tick(1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, i, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b1);
      for (int i = 1; i < 12; i++) begin
         if (i % 4 == 2) idle(2);
         tick(1'b0, 1'b0, 1'b1, (i + 5) % 7, 1'b1, (i == 11), 1'b0);
      end
      idle(4);

      sec = "rst_inflight";
      tick(1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, i, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b1, (i + 3) % 7, 1'b1, (i == 11), 1'b0);
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rgb565_to_gray.md
Name: rgb565_to_gray

Overview:
- Upstream neighbour of the Sobel edge stage. Converts the RGB565 camera/TFT pixel stream into 8-bit luma, one pixel per accepted input beat.
- Gates the stream to whole frames, PIC_W x PIC_H pixels after each frame-start pulse. The output pair po_flag/po_data drives the Sobel stage's ip_flag/ip_data directly.

Parameters:
- PIC_W, 480, active pixels per line
- PIC_H, 272, active lines per frame
- PIX_CNT_W, 24, width of the frame pixel counter; must hold PIC_W*PIC_H

Ports:
- tft_clk  input  1  single clock, all logic on its rising edge
- tft_rst  input  1  reset, synchronous and active-high
- vs_in  input  1  frame-start pulse, one cycle, precedes the first pixel of a frame
- pi_flag  input  1  pixel valid
- pi_data  input  16  RGB565 pixel: R[15:11], G[10:5], B[4:0]
- po_flag  output  1  gray pixel valid; feeds the Sobel stage's ip_flag
- po_data  output  8  gray value; feeds the Sobel stage's ip_data
- frame_done  output  1  one-cycle pulse coincident with the last po_flag of a frame
- frame_err  output  1  one-cycle pulse when vs_in arrives mid-frame

Behaviour:
- Reset: on tft_rst high at a clock edge, all of the following clear to 0: FSM to IDLE, pixel counter, all pipeline valid and data registers, po_flag, po_data, frame_done, frame_err. A reset mid-frame discards in-flight pixels, with no po_flag afterwards.
- FSM has two states, IDLE and ACTIVE.
  - IDLE: pi_flag is ignored. When vs_in=1, go to ACTIVE and set pix_cnt=0.
  - ACTIVE: each pi_flag=1 accepts a pixel and increments pix_cnt. On the accept where pix_cnt == PIC_W*PIC_H-1, tag that pixel "last", clear pix_cnt and return to IDLE.
  - Pixels beyond PIC_W*PIC_H in a frame are dropped, because the FSM is already IDLE.
- vs_in during ACTIVE:
  - If pix_cnt != 0, pulse frame_err one cycle later.
  - Always restart: pix_cnt=0 and stay ACTIVE. Pixels already in the pipeline still emerge, with no frame_done.
  - If pi_flag is also 1 in that cycle, the pixel is accepted as pixel 0 of the new frame.
- Colour expansion to 8 bits by MSB replication:
  - R8 = {R5, R5[4:2]}
  - G8 = {G6, G6[5:4]}
  - B8 = {B5, B5[4:2]}
- Luma: Y = (77*R8 + 150*G8 + 29*B8) >> 8, using unsigned 16-bit sums.
  - Maximum sum is 65280 (+128 with rounding), so there is no overflow and the result is at most 255.
- Pipeline: 3 stages, with valid and last bits travelling alongside the data.
  - S1: register the expanded channels.
  - S2: register the three products.
  - S3: register the sum, shifted.
- Latency: po_flag is asserted exactly 3 cycles after the accepting pi_flag edge. Throughput is 1 pixel per cycle; there is no backpressure.
- frame_done = S3 valid AND S3 last.
- po_data holds its last value when po_flag=0.

Optional Feature:
- Macro GRAY_ROUND_EN.
  - Defined: add 128 before the >>8 in S3, giving round-to-nearest.
  - Undefined: truncate.
- Latency is identical in both builds.

Test Plan:
- Reset, then pi_flag=1 with no vs_in for 100 cycles -> po_flag stays 0 throughout.
- vs_in, then pixels FFFF, F800, 07E0, 001F, 0000 on consecutive cycles -> po_flag high 3 cycles after each, po_data in order:
  - without GRAY_ROUND_EN: 255, 76, 149, 28, 0
  - with GRAY_ROUND_EN: 255, 77, 149, 29, 0
- Full frame, PIC_W=4, PIC_H=3: vs_in, then 14 pixels with gaps in pi_flag -> exactly 12 po_flag, frame_done on the 12th only, pixels 13 and 14 dropped.
- vs_in after 5 pixels of a frame -> frame_err pulses once, the 5 pixels still output with no frame_done, then a new frame of 12 pixels -> frame_done on the 12th.
- tft_rst asserted for 1 cycle while 2 pixels are in flight -> no po_flag afterwards, all outputs 0, FSM IDLE, next frame processed normally.
